// File: rtl/sm3_expnd.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm3_expnd : SM3 message expander, loads 16 words, emits Wj/W'j x 64       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module sm3_expnd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pad_otpt_d,
    input  logic        pad_otpt_vld,
    input  logic        pad_otpt_lst,
    output logic        pad_otpt_ena,
    output logic [31:0] expnd_otpt_wj,
    output logic [31:0] expnd_otpt_wjj,
    output logic        expnd_otpt_lst,
    output logic        expnd_otpt_vld
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        EXPND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  j_q, j_d;
    logic        blk_lst_q, blk_lst_d;
    logic        ena_q, ena_d;
    logic        vld_q, vld_d;
    logic        lst_q, lst_d;
    logic [31:0] wj_q, wj_d;
    logic [31:0] wjj_q, wjj_d;

    logic        xfer;
    logic [31:0] p1_in;
    logic [31:0] p1_out;
    logic [31:0] w_new;

    assign xfer   = pad_otpt_vld & ena_q;
    assign p1_in  = win_q[0] ^ win_q[7] ^ {win_q[13][16:0], win_q[13][31:17]};
    assign p1_out = p1_in ^ {p1_in[16:0], p1_in[31:17]} ^ {p1_in[8:0], p1_in[31:9]};
    assign w_new  = p1_out ^ {win_q[3][24:0], win_q[3][31:25]} ^ win_q[10];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        j_d       = '0;
        blk_lst_d = blk_lst_q;
        win_d     = win_q;

        case (state_q)
            IDLE: begin
                blk_lst_d = 1'b0;
                if (xfer) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (xfer && (cnt_q == 4'd15)) begin
                    state_d   = EXPND;
                    blk_lst_d = pad_otpt_lst;
                end
            end
            EXPND: begin
                j_d = j_q + 6'd1;
                if (j_q == 6'd63) begin
                    state_d   = IDLE;
                    blk_lst_d = 1'b0;
                    j_d       = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            cnt_d = cnt_q + 4'd1;
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[15] = pad_otpt_d;
        end else if (state_q == EXPND) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[15] = w_new;
        end

        // Outputs are registered from the next-state window so round j is
        // visible during the j-th EXPND cycle.
        ena_d = (state_d != EXPND);
        vld_d = (state_d == EXPND);
        wj_d  = vld_d ? win_d[0] : '0;
        wjj_d = vld_d ? (win_d[0] ^ win_d[4]) : '0;
        lst_d = vld_d & (j_d == 6'd63) & blk_lst_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            j_q       <= '0;
            blk_lst_q <= 1'b0;
            ena_q     <= 1'b0;
            vld_q     <= 1'b0;
            lst_q     <= 1'b0;
            wj_q      <= '0;
            wjj_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            j_q       <= j_d;
            blk_lst_q <= blk_lst_d;
            ena_q     <= ena_d;
            vld_q     <= vld_d;
            lst_q     <= lst_d;
            wj_q      <= wj_d;
            wjj_q     <= wjj_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign pad_otpt_ena   = ena_q;
    assign expnd_otpt_vld = vld_q;
    assign expnd_otpt_lst = lst_q;
    assign expnd_otpt_wj  = wj_q;
    assign expnd_otpt_wjj = wjj_q;

endmodule
`default_nettype wire

// File: tb/tb_sm3_expnd.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for sm3_expnd: scoreboard of Wj/W'j/lst fed by a reference expansion.
module tb_sm3_expnd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pad_otpt_d = '0;
    logic        pad_otpt_vld = 1'b0;
    logic        pad_otpt_lst = 1'b0;
    logic        pad_otpt_ena;
    logic [31:0] expnd_otpt_wj;
    logic [31:0] expnd_otpt_wjj;
    logic        expnd_otpt_lst;
    logic        expnd_otpt_vld;

    always #5 clk = ~clk;

    sm3_expnd dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pad_otpt_d     (pad_otpt_d),
        .pad_otpt_vld   (pad_otpt_vld),
        .pad_otpt_lst   (pad_otpt_lst),
        .pad_otpt_ena   (pad_otpt_ena),
        .expnd_otpt_wj  (expnd_otpt_wj),
        .expnd_otpt_wjj (expnd_otpt_wjj),
        .expnd_otpt_lst (expnd_otpt_lst),
        .expnd_otpt_vld (expnd_otpt_vld)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [64:0] sb [$];
    logic [31:0] blk [16];
    logic        blk_l;
    int          cyc = 0;
    int          cap_idx = 0;
    logic [31:0] cap_wj  [128];
    logic [31:0] cap_wjj [128];
    int          cap_cyc [128];
    logic [127:0] cap_lst;
    logic [31:0] ref_wj  [64];
    logic [31:0] ref_wjj [64];
    int          ena_runs [$];
    int          ena_run = 0;

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference expansion in the textbook W[j-16..j-3] form.
    function automatic void model_push();
        logic [31:0] w [68];
        logic [31:0] x;
        for (int j = 0; j < 16; j++) w[j] = blk[j];
        for (int j = 16; j < 68; j++) begin
            x    = w[j-16] ^ w[j-9] ^ rl(w[j-3], 15);
            w[j] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(w[j-13], 7) ^ w[j-6];
        end
        for (int j = 0; j < 64; j++) begin
            sb.push_back({w[j], w[j] ^ w[j+4], blk_l & (j == 63)});
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n) begin
            if (!pad_otpt_ena) ena_run++;
            else if (ena_run != 0) begin
                ena_runs.push_back(ena_run);
                ena_run = 0;
            end
            vectors++;
            if (expnd_otpt_vld) begin
                if (cap_idx < 128) begin
                    cap_wj[cap_idx]  = expnd_otpt_wj;
                    cap_wjj[cap_idx] = expnd_otpt_wjj;
                    cap_lst[cap_idx] = expnd_otpt_lst;
                    cap_cyc[cap_idx] = cyc;
                end
                cap_idx++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_vld: got wj=%h wjj=%h lst=%b, required no output",
                             expnd_otpt_wj, expnd_otpt_wjj, expnd_otpt_lst);
                end else begin
                    e = sb.pop_front();
                    if ({expnd_otpt_wj, expnd_otpt_wjj, expnd_otpt_lst} !== e) begin
                        miscompares++;
                        $display("FAIL sb_round: got wj=%h wjj=%h lst=%b, required wj=%h wjj=%h lst=%b",
                                 expnd_otpt_wj, expnd_otpt_wjj, expnd_otpt_lst, e[64:33], e[32:1], e[0]);
                    end
                end
            end else if ({expnd_otpt_wj, expnd_otpt_wjj, expnd_otpt_lst} !== 65'd0) begin
                miscompares++;
                $display("FAIL idle_zero: got wj=%h wjj=%h lst=%b, required all 0",
                         expnd_otpt_wj, expnd_otpt_wjj, expnd_otpt_lst);
            end
        end
    end

    task automatic send_block(input bit gapped);
        int i = 0;
        int guard = 0;
        bit gap;
        model_push();
        while (i < 16 && guard < 2000) begin
            @(negedge clk);
            guard++;
            gap = gapped && ($urandom_range(0, 2) == 0);
            if (gap) begin
                pad_otpt_vld = 1'b0;
                pad_otpt_d   = $urandom;
                pad_otpt_lst = 1'($urandom_range(0, 1));
            end else begin
                pad_otpt_vld = 1'b1;
                pad_otpt_d   = blk[i];
                pad_otpt_lst = (i == 15) ? blk_l : 1'($urandom_range(0, 1));
                if (pad_otpt_ena) i++;
            end
        end
        if (i < 16) begin
            vectors++;
            miscompares++;
            $display("FAIL load_timeout: got %0d words accepted, required 16", i);
        end
    endtask

    task automatic drain();
        int g = 0;
        @(negedge clk);
        pad_otpt_vld = 1'b0;
        while (sb.size() != 0 && g < 400) begin
            @(posedge clk);
            g++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending rounds, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        blk_l   = 1'b1;
    endtask

    task automatic load_random(input logic l);
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        blk_l = l;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({pad_otpt_ena, expnd_otpt_vld, expnd_otpt_lst, expnd_otpt_wj, expnd_otpt_wjj} !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ena=%b vld=%b lst=%b wj=%h wjj=%h, required all 0",
                     pad_otpt_ena, expnd_otpt_vld, expnd_otpt_lst, expnd_otpt_wj, expnd_otpt_wjj);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (pad_otpt_ena !== 1'b0) begin
            miscompares++;
            $display("FAIL ena_before_edge: got %b, required 0", pad_otpt_ena);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (pad_otpt_ena !== 1'b1) begin
            miscompares++;
            $display("FAIL ena_after_release: got %b, required 1", pad_otpt_ena);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_abc();
        load_abc();
        cap_idx = 0;
        cap_lst = '0;
        send_block(1'b0);
        drain();
        vectors += 10;
        if (cap_idx !== 64) begin miscompares++; $display("FAIL abc_vld_count: got %0d, required 64", cap_idx); end
        if (cap_cyc[63] - cap_cyc[0] !== 63) begin miscompares++; $display("FAIL abc_consecutive: got span %0d, required 63", cap_cyc[63] - cap_cyc[0]); end
        if (cap_wj[0]  !== 32'h61626380) begin miscompares++; $display("FAIL abc_wj0: got %h, required 61626380", cap_wj[0]); end
        if (cap_wj[15] !== 32'h00000018) begin miscompares++; $display("FAIL abc_wj15: got %h, required 00000018", cap_wj[15]); end
        if (cap_wj[16] !== 32'h9092E200) begin miscompares++; $display("FAIL abc_wj16: got %h, required 9092e200", cap_wj[16]); end
        if (cap_wj[17] !== 32'h00000000) begin miscompares++; $display("FAIL abc_wj17: got %h, required 00000000", cap_wj[17]); end
        if (cap_wj[18] !== 32'h000C0606) begin miscompares++; $display("FAIL abc_wj18: got %h, required 000c0606", cap_wj[18]); end
        if (cap_wjj[0]  !== 32'h61626380) begin miscompares++; $display("FAIL abc_wjj0: got %h, required 61626380", cap_wjj[0]); end
        if (cap_wjj[12] !== 32'h9092E200) begin miscompares++; $display("FAIL abc_wjj12: got %h, required 9092e200", cap_wjj[12]); end
        if (cap_lst[63:0] !== 64'h8000_0000_0000_0000) begin miscompares++; $display("FAIL abc_lst: got %h, required 8000000000000000", cap_lst[63:0]); end
    endtask

    task automatic test_back_to_back();
        ena_runs.delete();
        ena_run = 0;
        cap_idx = 0;
        cap_lst = '0;
        load_random(1'b0);
        send_block(1'b0);
        load_random(1'b1);
        send_block(1'b0);
        drain();
        vectors += 3;
        if (ena_runs.size() !== 2) begin
            miscompares++;
            $display("FAIL b2b_ena_runs: got %0d low periods, required 2", ena_runs.size());
        end else if (ena_runs[0] !== 64 || ena_runs[1] !== 64) begin
            miscompares++;
            $display("FAIL b2b_ena_len: got %0d and %0d, required 64 and 64", ena_runs[0], ena_runs[1]);
        end
        if (cap_idx !== 128) begin
            miscompares++;
            $display("FAIL b2b_vld_count: got %0d, required 128", cap_idx);
        end
        if (cap_lst !== {1'b1, 127'd0}) begin
            miscompares++;
            $display("FAIL b2b_lst: got %h, required 80000000000000000000000000000000", cap_lst);
        end
    endtask

    task automatic test_gapped();
        load_random(1'($urandom_range(0, 1)));
        cap_idx = 0;
        send_block(1'b0);
        drain();
        for (int k = 0; k < 64; k++) begin
            ref_wj[k]  = cap_wj[k];
            ref_wjj[k] = cap_wjj[k];
        end
        cap_idx = 0;
        send_block(1'b1);
        drain();
        for (int k = 0; k < 64; k++) begin
            vectors++;
            if (cap_wj[k] !== ref_wj[k] || cap_wjj[k] !== ref_wjj[k]) begin
                miscompares++;
                $display("FAIL gapped_vs_gapless j=%0d: got wj=%h wjj=%h, required wj=%h wjj=%h",
                         k, cap_wj[k], cap_wjj[k], ref_wj[k], ref_wjj[k]);
            end
        end
    endtask

    task automatic test_vld_during_expnd();
        load_random(1'b1);
        send_block(1'b0);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            pad_otpt_vld = 1'b1;
            pad_otpt_d   = $urandom;
            pad_otpt_lst = 1'($urandom_range(0, 1));
            vectors++;
            if (pad_otpt_ena !== 1'b0) begin
                miscompares++;
                $display("FAIL expnd_ena round %0d: got %b, required 0", k, pad_otpt_ena);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int g = 0;
        load_abc();
        cap_idx = 0;
        send_block(1'b0);
        @(negedge clk);
        pad_otpt_vld = 1'b0;
        while (cap_idx < 30 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        vectors++;
        if ({pad_otpt_ena, expnd_otpt_vld, expnd_otpt_lst, expnd_otpt_wj, expnd_otpt_wjj} !== 67'd0) begin
            miscompares++;
            $display("FAIL midreset_async: got ena=%b vld=%b lst=%b wj=%h wjj=%h, required all 0",
                     pad_otpt_ena, expnd_otpt_vld, expnd_otpt_lst, expnd_otpt_wj, expnd_otpt_wjj);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (pad_otpt_ena !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_ena: got %b, required 1", pad_otpt_ena);
        end
        cap_idx = 0;
        cap_lst = '0;
        send_block(1'b0);
        drain();
        vectors += 5;
        if (cap_idx !== 64) begin miscompares++; $display("FAIL midreset_count: got %0d, required 64", cap_idx); end
        if (cap_wj[16] !== 32'h9092E200) begin miscompares++; $display("FAIL midreset_wj16: got %h, required 9092e200", cap_wj[16]); end
        if (cap_wj[18] !== 32'h000C0606) begin miscompares++; $display("FAIL midreset_wj18: got %h, required 000c0606", cap_wj[18]); end
        if (cap_wjj[12] !== 32'h9092E200) begin miscompares++; $display("FAIL midreset_wjj12: got %h, required 9092e200", cap_wjj[12]); end
        if (cap_lst[63:0] !== 64'h8000_0000_0000_0000) begin miscompares++; $display("FAIL midreset_lst: got %h, required 8000000000000000", cap_lst[63:0]); end
    endtask

    task automatic test_random();
        for (int b = 0; b < 200; b++) begin
            load_random(1'($urandom_range(0, 1)));
            send_block(1'($urandom_range(0, 1)));
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_back_to_back();
        test_gapped();
        test_vld_during_expnd();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
